// File: rtl/t2s_stream.sv
`timescale 1ns/1ps
// Streaming T2S/S2T coefficient lane reorder with per-vector length, group size and direction.
// 2-cycle latency; a stalled output holds steady and in_ready falls only when both stages are full.
module t2s_stream #(
    parameter int WIDTH    = 16,
    parameter int MAX_LEN  = 32,
    parameter int LOG2_MAX = $clog2(MAX_LEN),
    parameter int LW       = $clog2(LOG2_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MAX_LEN*WIDTH-1:0] in_data,
    input  logic [LW-1:0]            in_len_log2,
    input  logic [LW-1:0]            in_grp_log2,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAX_LEN*WIDTH-1:0] out_data,
    output logic                     out_cfg_err,
    output logic [15:0]              out_count
);

    localparam int DW = MAX_LEN * WIDTH;
    localparam int PW = LOG2_MAX + 1;
    typedef logic [PW-1:0] pos_t;

    logic          s1_vld_q;
    logic [DW-1:0] s1_dat_q;
    logic [LW-1:0] s1_len_q;
    logic [LW-1:0] s1_grp_q;
    logic          s1_inv_q;
    logic          s1_legal_q;
    logic          s2_vld_q;
    logic [DW-1:0] s2_dat_q;
    logic [DW-1:0] s2_dat_d;
    logic          s2_err_q;
    logic [15:0]   cnt_q;
    logic          s1_en;
    logic          s2_en;
    logic          in_legal;

    assign s2_en    = !s2_vld_q || out_ready;
    assign s1_en    = !s1_vld_q || s2_en;
    assign in_ready = s1_en;

    assign in_legal = (in_grp_log2 >= LW'(2)) && (in_grp_log2 <= in_len_log2)
                   && (in_len_log2 <= LW'(LOG2_MAX));

    // Lanes default to pass-through; only active lanes of a legal vector are rerouted.
    always_comb begin
        logic [WIDTH-1:0] lane_in  [MAX_LEN];
        logic [WIDTH-1:0] lane_out [MAX_LEN];
        pos_t n_v, half_v, l_v, pos_v, r_v, p_v, base_v, np_v;
        n_v      = pos_t'(1) << s1_grp_q;
        half_v   = n_v >> 1;
        l_v      = pos_t'(1) << s1_len_q;
        pos_v    = '0;
        r_v      = '0;
        p_v      = '0;
        base_v   = '0;
        np_v     = '0;
        s2_dat_d = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lane_in[i]  = s1_dat_q[i*WIDTH +: WIDTH];
            lane_out[i] = s1_dat_q[i*WIDTH +: WIDTH];
        end
        if (s1_legal_q) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pos_v  = pos_t'(i);
                r_v    = pos_v & (n_v - pos_t'(1));
                p_v    = {{(PW-1){1'b0}}, pos_v[0]};
                base_v = pos_v & ~(n_v - pos_t'(1));
                if (r_v < half_v)
                    np_v = base_v + (r_v << 1) - p_v;
                else
                    np_v = base_v + n_v - pos_t'(1) - ((r_v - p_v - half_v) << 1)
                         - (pos_t'(1) - p_v);
                if (pos_v < l_v) begin
                    if (s1_inv_q)
                        lane_out[i] = lane_in[np_v[LOG2_MAX-1:0]];
                    else
                        lane_out[np_v[LOG2_MAX-1:0]] = lane_in[i];
                end
            end
        end
        for (int i = 0; i < MAX_LEN; i++)
            s2_dat_d[i*WIDTH +: WIDTH] = lane_out[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_len_q   <= '0;
            s1_grp_q   <= '0;
            s1_inv_q   <= 1'b0;
            s1_legal_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_dat_q   <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_en) begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    s1_dat_q   <= in_data;
                    s1_len_q   <= in_len_log2;
                    s1_grp_q   <= in_grp_log2;
                    s1_inv_q   <= in_inv;
                    s1_legal_q <= in_legal;
                end
            end
            if (s2_en) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_dat_q <= s2_dat_d;
                    s2_err_q <= !s1_legal_q;
                end
            end
            if (s2_vld_q && out_ready)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_valid   = s2_vld_q;
    assign out_data    = s2_dat_q;
    assign out_cfg_err = s2_err_q;
    assign out_count   = cnt_q;

endmodule

// File: tb/tb_t2s_stream.sv
`timescale 1ns/1ps
// Random and directed stimulus for t2s_stream, scored against a lane-index reference model.
module tb_t2s_stream;

    localparam int WIDTH    = 16;
    localparam int MAX_LEN  = 32;
    localparam int LOG2_MAX = 5;
    localparam int LW       = 3;
    localparam int DW       = MAX_LEN * WIDTH;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_len_log2;
    logic [LW-1:0] in_grp_log2;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_cfg_err;
    logic [15:0]   out_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            bp_mode  = 0;
    exp_t          q[$];
    logic [DW-1:0] last_dat = '0;
    logic          last_err = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic          prev_err = 1'b0;

    t2s_stream #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_len_log2 (in_len_log2),
        .in_grp_log2 (in_grp_log2),
        .in_inv      (in_inv),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cfg_err (out_cfg_err),
        .out_count   (out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference: move lane pos to np (forward) or fetch lane np into pos (inverse).
    function automatic exp_t model(input logic [DW-1:0] d, input int len, input int grp, input bit inv);
        exp_t r;
        logic [WIDTH-1:0] a [MAX_LEN];
        logic [WIDTH-1:0] b [MAX_LEN];
        int L, N, R, p, base, np;
        for (int i = 0; i < MAX_LEN; i++) a[i] = d[i*WIDTH +: WIDTH];
        b   = a;
        r.e = !(grp >= 2 && grp <= len && len <= LOG2_MAX);
        if (!r.e) begin
            L = 1 << len;
            N = 1 << grp;
            for (int pos = 0; pos < L; pos++) begin
                R    = pos % N;
                p    = R % 2;
                base = (pos / N) * N;
                if (R < N / 2) np = base + 2 * R - p;
                else           np = base + N - 1 - 2 * (R - p - N / 2) - (1 - p);
                if (inv) b[pos] = a[np];
                else     b[np]  = a[pos];
            end
        end
        r.d = '0;
        for (int i = 0; i < MAX_LEN; i++) r.d[i*WIDTH +: WIDTH] = b[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] idx_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < MAX_LEN; i++) v[i*WIDTH +: WIDTH] = WIDTH'(i);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < MAX_LEN; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_vld", DW'(out_valid), DW'(1));
                check("stall_dat", out_data, prev_dat);
                check("stall_err", DW'(out_cfg_err), DW'(prev_err));
            end
            if (out_valid && out_ready) begin
                check("out_expected", DW'(q.size() != 0), DW'(1));
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_dat", out_data, e.d);
                    check("out_err", DW'(out_cfg_err), DW'(e.e));
                end
                last_dat = out_data;
                last_err = out_cfg_err;
            end
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_err   = out_cfg_err;
        end
    end

    task automatic send(input logic [DW-1:0] d, input int len, input int grp, input bit inv);
        bit acc;
        acc         = 1'b0;
        in_valid    = 1'b1;
        in_data     = d;
        in_len_log2 = LW'(len);
        in_grp_log2 = LW'(grp);
        in_inv      = inv;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                q.push_back(model(d, len, grp, inv));
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        check("send_accept", DW'(acc), DW'(1));
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("drain", DW'(q.size()), DW'(0));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cfg(output int len, output int grp);
        if ($urandom_range(0, 4) != 0) begin
            grp = int'($urandom_range(2, LOG2_MAX));
            len = int'($urandom_range(grp, LOG2_MAX));
        end else begin
            grp = int'($urandom_range(0, 7));
            len = int'($urandom_range(0, 7));
        end
    endtask

    initial begin
        logic [DW-1:0] v, e, t;
        int f8[8] = '{0, 1, 6, 7, 2, 3, 4, 5};
        int len, grp;

        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_len_log2 = '0;
        in_grp_log2 = '0;
        in_inv      = 1'b0;
        #3 rst_n = 1'b0;
        #10;
        check("rst0_vld", DW'(out_valid), DW'(0));
        check("rst0_dat", out_data, '0);
        check("rst0_err", DW'(out_cfg_err), DW'(0));
        check("rst0_cnt", DW'(out_count), DW'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst0_in_rdy", DW'(in_ready), DW'(1));
        @(posedge clk);
        #2;

        v = idx_vec();
        send(v, 3, 3, 1'b0);
        wait_drain();
        e = v;
        for (int i = 0; i < 8; i++) e[i*WIDTH +: WIDTH] = WIDTH'(f8[i]);
        check("fwd8_dat", last_dat, e);
        check("fwd8_err", DW'(last_err), DW'(0));

        send(e, 3, 3, 1'b1);
        wait_drain();
        check("inv8_dat", last_dat, v);

        send(v, 5, 4, 1'b0);
        wait_drain();
        check("fwd16_l14", DW'(last_dat[14*WIDTH +: WIDTH]), DW'(8));
        check("fwd16_l3", DW'(last_dat[3*WIDTH +: WIDTH]), DW'(15));
        check("fwd16_l20", DW'(last_dat[20*WIDTH +: WIDTH]), DW'(18));
        t = last_dat;
        send(t, 5, 4, 1'b1);
        wait_drain();
        check("inv16_dat", last_dat, v);

        send(v, 3, 1, 1'b0);
        wait_drain();
        check("ill_grp1_dat", last_dat, v);
        check("ill_grp1_err", DW'(last_err), DW'(1));
        send(v, 3, 4, 1'b0);
        wait_drain();
        check("ill_grp_gt_len_dat", last_dat, v);
        check("ill_grp_gt_len_err", DW'(last_err), DW'(1));
        send(v, 6, 2, 1'b1);
        wait_drain();
        check("ill_len_big_dat", last_dat, v);
        check("ill_len_big_err", DW'(last_err), DW'(1));
        send(v, 3, 3, 1'b0);
        wait_drain();
        check("legal_after_ill_err", DW'(last_err), DW'(0));

        do_reset();
        bp_mode = 1;
        for (int k = 0; k < 10; k++) begin
            rand_cfg(len, grp);
            send(rand_vec(), len, grp, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        check("bp_count", DW'(out_count), DW'(10));

        bp_mode = 2;
        @(posedge clk);
        #2;
        send(rand_vec(), 5, 3, 1'b0);
        send(rand_vec(), 4, 2, 1'b1);
        check("pre_rst_vld", DW'(out_valid), DW'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", DW'(out_valid), DW'(0));
        check("mid_rst_cnt", DW'(out_count), DW'(0));
        q.delete();
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        send(rand_vec(), 5, 5, 1'b0);
        check("lat_edge_k", DW'(out_valid), DW'(0));
        @(posedge clk);
        #2;
        check("lat_edge_k1", DW'(out_valid), DW'(1));
        wait_drain();

        bp_mode = 1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
            rand_cfg(len, grp);
            send(rand_vec(), len, grp, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        check("final_cnt", DW'(out_count), DW'(151));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/t2s_stream.md
# t2s_stream

Streaming, parametrised successor to the combinational RMTS T2S coefficient reorder. It accepts one coefficient vector per cycle over a valid/ready handshake. Each vector carries its own active length, permutation group size and direction (forward T2S or inverse S2T). The result leaves through a two-stage elastic pipeline. The block sits in the saus-input-selection path between coefficient buffering and the transform-selection datapath.

## Interface
- WIDTH, 16, signed coefficient width
- MAX_LEN, 32, lane count; power of two, at least 4
- LOG2_MAX, $clog2(MAX_LEN), derived; LW = $clog2(LOG2_MAX+1), derived
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  MAX_LEN*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_len_log2  in  LW  active length L = 1<<in_len_log2
- in_grp_log2  in  LW  group size N = 1<<in_grp_log2
- in_inv  in  1  0 = forward T2S, 1 = inverse S2T
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_data  out  MAX_LEN*WIDTH  permuted vector, same lane packing
- out_cfg_err  out  1  this output vector had an illegal config and was passed through
- out_count  out  16  count of completed output handshakes, wraps 0xFFFF->0

## Operation
- Handshake: a transfer occurs when valid && ready. in_data and config are sampled together.
- Configuration is legal iff 2 <= in_grp_log2 <= in_len_log2 <= LOG2_MAX.
- Illegal configuration: out_data = in_data unchanged and out_cfg_err = 1. The vector is never dropped.
- Forward permutation, for each pos < L:
  - R = pos mod N, p = R mod 2, base = (pos/N)*N.
  - If R < N/2: np = base + 2R - p.
  - Else: np = base + N-1 - 2(R-p-N/2) - (1-p).
  - out[np] = in[pos].
- Inverse permutation: out[pos] = in[np(pos)], using the same np. Forward followed by inverse is identity.
- Lanes pos >= L pass through unchanged in both modes.
- N=4 is identity within each group and legal.
- Datapath is pure lane routing: no arithmetic, no saturation, sign bits preserved.
- Pipeline S1 registers in_data, config and the legality flag. S2 registers the permuted data and err flag. out_* are driven from S2.
- Enables:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en, combinational from out_ready
- Stall: while out_valid && !out_ready, out_data, out_cfg_err and out_valid hold stable. No overwrite or loss occurs.
- out_count increments by 1 on each out_valid && out_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - s1_valid = s2_valid = 0, out_valid = 0, out_data = 0, out_cfg_err = 0, out_count = 0.
  - in_ready = 1 once rst_n is released, since the pipeline is empty.
- Latency: a vector accepted at edge k is presented with out_valid = 1 after edge k+1. Two register stages, 2 cycles.
- Throughput: 1 vector/cycle while out_ready = 1.
- Full: both stages valid and out_ready = 0 gives in_ready = 0.
- Simultaneous accept and drain in one cycle is allowed when full. in_ready is 1 if out_ready is 1.
- Reset mid-stream discards all in-flight vectors. No partial output appears after reset.
- Config changes between consecutive vectors take effect per vector. No bubble is inserted.

## Test plan
- Forward, L=8 (len_log2=3), N=8, lanes = index 0..31 -> after 2 cycles lanes 0..7 = {0,1,6,7,2,3,4,5}, lanes 8..31 = 8..31, out_cfg_err = 0.
- Inverse, same config, input {0,1,6,7,2,3,4,5,8..31} -> output 0..31.
- L=32, N=16, forward, lanes = index -> out[14] = 8, out[3] = 15, out[16+4] = 18. Then feed the result back with inv=1 -> original vector.
- Illegal configs:
  - grp_log2 = 1 -> pass-through, out_cfg_err = 1.
  - grp_log2 = 4 with len_log2 = 3 -> pass-through, out_cfg_err = 1.
  - Next legal vector -> out_cfg_err = 0.
- Backpressure: 10 back-to-back vectors, out_ready toggling randomly -> output order preserved, out_data stable during stalls, no loss, out_count = 10.
- Assert rst_n low with 2 vectors in flight -> out_valid = 0 immediately, out_count = 0. After release, the first new vector appears at 2-cycle latency.
